// File: rtl/fib_req_arbiter.sv
// fib_req_arbiter: round-robin sharing of one fibonacci engine among
// NUM_REQ requesters; every output is registered.
module fib_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 5,
  parameter int RES_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [RES_W-1:0]         rsp_f,
  output logic                     busy,
  input  logic                     eng_ready,
  output logic                     eng_start,
  output logic [IDX_W-1:0]         eng_i,
  input  logic                     eng_done,
  input  logic [RES_W-1:0]         eng_f
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] owner_q;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] cand;
  logic [PTR_W:0]   sum;
  logic             found;

  // Scan last+1, last+2, ... modulo NUM_REQ; first pending wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (found && eng_ready) state_d = START;
      START: state_d = eng_done ? RESP : WAIT;
      WAIT:  if (eng_done) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= PTR_W'(NUM_REQ-1);
      owner_q   <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_f     <= '0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_i     <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      req_ack   <= '0;
      eng_start <= 1'b0;
      rsp_valid <= '0;
      if (state_q == IDLE && state_d == START) begin
        owner_q   <= win;
        last_q    <= win;
        req_ack   <= NUM_REQ'(1) << win;
        eng_start <= 1'b1;
        eng_i     <= IDX_W'(req_idx >> (int'(win) * IDX_W));
      end
      // Result is captured on the same edge that enters RESP.
      if (state_d == RESP) begin
        rsp_valid <= NUM_REQ'(1) << owner_q;
        rsp_f     <= eng_f;
      end
    end
  end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// tb_fib_req_arbiter: random requesters and engine model, scoreboard
// checked against a round-robin reference model.
module tb_fib_req_arbiter;

  localparam int N  = 4;
  localparam int IW = 5;
  localparam int RW = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*IW-1:0] req_idx;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    rsp_valid;
  logic [RW-1:0]   rsp_f;
  logic            busy;
  logic            eng_ready;
  logic            eng_start;
  logic [IW-1:0]   eng_i;
  logic            eng_done;
  logic [RW-1:0]   eng_f;

  always #5 clk = ~clk;

  fib_req_arbiter #(.NUM_REQ(N), .IDX_W(IW), .RES_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_idx(req_idx),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_f(rsp_f),
    .busy(busy), .eng_ready(eng_ready), .eng_start(eng_start),
    .eng_i(eng_i), .eng_done(eng_done), .eng_f(eng_f)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            own;
    logic [RW-1:0] f;
  } exp_t;

  exp_t          sbq[$];
  int            ptr = N-1;
  bit            free = 1'b1;
  int            idle_in = 0;
  bit            job = 1'b0;
  logic [RW-1:0] last_f = '0;

  bit [N-1:0]    rereq = '0;
  bit            rand_on = 1'b0;
  bit            spur_on = 1'b0;
  bit            ready_en = 1'b1;
  int            force_lat = 0;
  int            cnt = 0;
  logic [IW-1:0] lat_i = '0;

  function automatic logic [RW-1:0] fib(int n);
    logic [RW-1:0] a, b, t;
    a = '0;
    b = RW'(1);
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic bit bit_at(logic [N-1:0] x, int k);
    logic [N-1:0] s;
    s = x >> k;
    return s[0];
  endfunction

  function automatic logic [IW-1:0] idx_at(logic [N*IW-1:0] x, int k);
    return IW'(x >> (k*IW));
  endfunction

  function automatic logic [N-1:0] oh(int k);
    return N'(1) << k;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(int k, int i);
    logic [N*IW-1:0] m, d;
    m = (N*IW)'({IW{1'b1}}) << (k*IW);
    d = (N*IW)'(IW'(i)) << (k*IW);
    req_idx   = (req_idx & ~m) | d;
    req_valid = req_valid | oh(k);
  endtask

  // Monitor / scoreboard: round-robin reference and response checking.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_outputs",
            64'({req_ack, rsp_valid, eng_start, busy, eng_i, rsp_f}), 64'd0);
        ptr = N-1;
        free = 1'b1;
        idle_in = 0;
        job = 1'b0;
        sbq.delete();
      end else begin
        logic [N-1:0] exp_ack;
        int w;
        if (idle_in > 0) begin
          idle_in--;
          if (idle_in == 0) free = 1'b1;
        end
        exp_ack = '0;
        w = -1;
        if (free && req_valid != '0 && eng_ready) begin
          for (int o = 1; o <= N; o++) begin
            int c;
            c = (ptr + o) % N;
            if (w < 0 && bit_at(req_valid, c)) w = c;
          end
          exp_ack = oh(w);
          chk("eng_i", 64'(eng_i), 64'(idx_at(req_idx, w)));
          sbq.push_back('{own: w, f: fib(int'(idx_at(req_idx, w)))});
          ptr = w;
          free = 1'b0;
          job = 1'b1;
        end
        chk("req_ack", 64'(req_ack), 64'(exp_ack));
        chk("eng_start", 64'(eng_start), 64'(exp_ack != '0));
        chk("busy", 64'(busy), 64'(job));
        if (rsp_valid != '0) begin
          if (sbq.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_onehot", 64'(rsp_valid), 64'(oh(e.own)));
            chk("rsp_f", 64'(rsp_f), 64'(e.f));
          end
          last_f = rsp_f;
          job = 1'b0;
          idle_in = 2;
        end
      end
    end
  end

  // One cycle of engine and requester behaviour, applied at negedge.
  task automatic step();
    @(negedge clk);
    eng_done = 1'b0;
    eng_f = RW'($urandom);
    if (eng_start) begin
      lat_i = eng_i;
      cnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        eng_done = 1'b1;
        eng_f = fib(int'(lat_i));
      end
    end else if (spur_on && $urandom_range(0, 7) == 0) begin
      eng_done = 1'b1;
    end
    eng_ready = ready_en && cnt == 0 && !eng_start;
    for (int k = 0; k < N; k++) begin
      if (bit_at(req_ack, k)) begin
        if (!bit_at(rereq, k)) req_valid = req_valid & ~oh(k);
      end else if (rand_on) begin
        if (!bit_at(req_valid, k)) begin
          if ($urandom_range(0, 3) == 0)
            set_req(k, int'($urandom_range(0, 31)));
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid = req_valid & ~oh(k);
        end
      end
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      step();
      if (req_valid == '0 && sbq.size() == 0 && !job && cnt == 0)
        ok = 1'b1;
    end
    chk("drain_timeout", 64'(ok), 64'd1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cnt = 0;
    eng_done = 1'b0;
    eng_ready = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_async",
        64'({req_ack, rsp_valid, eng_start, busy, eng_i, rsp_f}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    eng_ready = ready_en;
  endtask

  initial begin
    bit ok;
    req_valid = '0;
    req_idx = '0;
    eng_ready = 1'b0;
    eng_done = 1'b0;
    eng_f = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    eng_ready = 1'b1;

    set_req(1, 10);
    drain();
    chk("fib10", 64'(last_f), 64'd55);

    do_reset();
    for (int k = 0; k < N; k++) set_req(k, k + 5);
    drain();
    chk("fib8", 64'(last_f), 64'd21);

    rereq = 4'b0001;
    set_req(0, 3);
    set_req(2, 4);
    repeat (30) step();
    rereq = '0;
    drain();

    ready_en = 1'b0;
    set_req(3, 7);
    repeat (10) step();
    ready_en = 1'b1;
    drain();

    force_lat = 8;
    set_req(1, 9);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (cnt > 0 && cnt < 7) ok = 1'b1;
    end
    chk("wait_reach", 64'(ok), 64'd1);
    do_reset();
    force_lat = 0;
    set_req(0, 2);
    set_req(3, 4);
    drain();
    chk("fib4", 64'(last_f), 64'd3);

    set_req(2, 0);
    drain();
    chk("fib0", 64'(last_f), 64'd0);
    set_req(1, 30);
    drain();
    chk("fib30", 64'(last_f), 64'd832040);

    rand_on = 1'b1;
    spur_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      ready_en = ($urandom_range(0, 5) != 0);
      step();
    end
    rand_on = 1'b0;
    spur_on = 1'b0;
    ready_en = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
